mac_acc512_seq: RTL
===================

// Module: mac_acc512_seq
// PURPOSE
//  512-bit accumulator for the MAC_512 datapath: acc <= acc + in_data (mod 2^512).
//  Reuses one CLA128 instance time-multiplexed over four 128-bit slices, LSB slice first.
//  Carry is rippled between slices through a register.
//  Sits downstream of the multiplier/partial-product stage. Owns the CLA128 as its adder core.
// PARAMETERS
//  W      512  accumulator / operand width (fixed; must equal BEATS*SLICE)
//  SLICE  128  adder slice width (width of the CLA128 instance)
//  BEATS  4    derived localparam W/SLICE; beat counter is 2 bits wide
// PORTS
//  clk       in   1    single clock, rising edge
//  rst       in   1    synchronous, active-high reset
//  clr       in   1    synchronous clear of accumulator and ovf (see priority rules)
//  in_valid  in   1    operand valid
//  in_ready  out  1    block can accept an operand this cycle
//  in_data   in   512  addend
//  acc_out   out  512  accumulator register (direct register output)
//  out_valid out  1    one-cycle pulse: accumulation result on acc_out is complete
//  busy      out  1    high while in ADD state
//  ovf       out  1    sticky: set when a completed add produced carry-out from bit 511
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, acc_out=0, op_reg=0, beat=0, carry=0.
//   Outputs after reset: out_valid=0, ovf=0, busy=0. Then in_ready=1.
//  States: IDLE, ADD.
//  IDLE: in_ready = ~clr.
//   On in_valid & in_ready, at edge t: op_reg<=in_data, beat<=0, carry<=0, go to ADD.
//  ADD, beats k=0..3 at edges t+1..t+4:
//   - CLA128 inputs: A=acc[128k+127:128k], B=op_reg[128k+127:128k], Ci=carry.
//   - acc slice k <= S; carry <= Cout; beat <= beat+1.
//   - Slices other than k are unchanged.
//  On beat 3 (edge t+4): return to IDLE; out_valid<=1 for exactly one cycle; ovf <= ovf | Cout.
//  Latency: operand accepted at edge t -> final acc_out and out_valid visible after edge t+4.
//  Throughput: one operand per 5 cycles.
//   in_ready is high in the same cycle as out_valid, so the next accept occurs at edge t+5.
//  in_ready=0 and busy=1 throughout ADD. in_data and in_valid are ignored during ADD.
//  acc_out is partially updated during ADD. Consumers may sample it only when out_valid=1 or in IDLE.
//  Arithmetic: unsigned, modulo 2^512. Inter-slice carry is exact (full 512-bit add).
//  Only the bit-511 carry feeds ovf. Intermediate slice carries never set ovf.
//  clr (priority rst > clr > add):
//   - clr=1 in IDLE: acc<=0, ovf<=0, carry<=0. No operand accepted (in_ready=0 that cycle).
//   - clr=1 in ADD: abort. acc<=0, ovf<=0, carry<=0, beat<=0, go to IDLE. No out_valid pulse.
//   - clr=1 on the beat-3 edge: abort wins. acc=0, ovf=0, out_valid stays 0.
//  rst mid-operation: identical to the reset state above. The in-flight operand is discarded.
//  No combinational path from in_valid to in_ready. in_ready depends only on state and clr.
// TESTING
//  1 Reset: assert rst 2 cycles.
//    -> acc_out=0, ovf=0, out_valid=0, busy=0, in_ready=1.
//  2 Basic add: acc=0, add 512'h5, then add 512'h3.
//    -> out_valid 4 cycles after each accept; acc_out=512'h8, ovf=0.
//  3 Slice carry chain: acc=0, add {384'h0,128'hFFFF..F}, then add 512'h1.
//    -> acc_out={383'h0,1'b1,128'h0}; repeat across all boundaries to give 2^384.
//  4 Overflow: acc=all-ones (512'hFF..F), add 512'h1.
//    -> acc_out=0, ovf=1. ovf stays 1 after a further add of 512'h2; clr -> ovf=0.
//  5 Back-to-back: in_valid held high with 3 operands (1,2,3).
//    -> accepts spaced exactly 5 cycles; three out_valid pulses; final acc_out=6.
//  6 Abort: clr at beat 2 of an add of all-ones onto 512'h1.
//    -> no out_valid, acc_out=0, in_ready=1 next cycle.
//    Repeat using rst instead of clr: same result.

Source files
------------

// File: rtl/mac_acc512_seq.sv
// 512-bit sequential accumulator: acc <= acc + in_data (mod 2^512), computed over four
// beats through one shared 128-bit carry-lookahead adder, LSB slice first.

module cla128 (
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         ci,
    output logic [127:0] s,
    output logic         co
);
    logic [127:0] g;
    logic [127:0] p;
    logic [128:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit lookahead groups; group carries chain from group to group.
    always_comb begin
        c = '0;
        c[0] = ci;
        for (int j = 0; j < 32; j++) begin
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
        end
    end

    assign s  = p ^ c[127:0];
    assign co = c[128];
endmodule

module mac_acc512_seq #(
    parameter int W     = 512,
    parameter int SLICE = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] acc_out,
    output logic         out_valid,
    output logic         busy,
    output logic         ovf
);
    localparam int BEATS = W / SLICE;

    typedef enum logic {IDLE, ADD} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     beat;
    logic           carry;
    logic [W-1:0]   op_reg;
    logic [SLICE-1:0] sum;
    logic           cout;
    logic           last_beat;

    assign last_beat = (beat == 2'(BEATS - 1));

    cla128 u_cla (
        .a  (acc_out[beat*SLICE +: SLICE]),
        .b  (op_reg[beat*SLICE +: SLICE]),
        .ci (carry),
        .s  (sum),
        .co (cout)
    );

    // NOTE: every register below uses non-blocking assignment so all state updates
    // see the pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid && in_ready) state_nxt = ADD;
            ADD:  if (clr || last_beat)     state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // in_ready depends only on state and clr, never on in_valid.
    always_comb begin
        in_ready = (state == IDLE) && !clr;
        busy     = (state == ADD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out   <= '0;
            op_reg    <= '0;
            beat      <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                // Abort wins over a completing beat: no pulse, no ovf update.
                acc_out <= '0;
                ovf     <= 1'b0;
                carry   <= 1'b0;
                beat    <= '0;
            end else if (state == IDLE) begin
                if (in_valid) begin
                    op_reg <= in_data;
                    beat   <= '0;
                    carry  <= 1'b0;
                end
            end else begin
                acc_out[beat*SLICE +: SLICE] <= sum;
                carry <= cout;
                beat  <= beat + 2'd1;
                if (last_beat) begin
                    out_valid <= 1'b1;
                    ovf       <= ovf | cout;
                end
            end
        end
    end
endmodule
